// File: rtl/mips_multicycle_if.sv
// mips_multicycle_if: shared instruction/data memory port of the multicycle MIPS core.
// The core drives the request side (master). The memory answers with data and ready (slave).
interface mips_multicycle_if;
    logic        memreq;
    logic        memwe;
    logic [31:0] memaddr;
    logic [31:0] memwdata;
    logic [31:0] memrdata;
    logic        memready;

    modport master (
        output memreq,
        output memwe,
        output memaddr,
        output memwdata,
        input  memrdata,
        input  memready
    );

    modport slave (
        input  memreq,
        input  memwe,
        input  memaddr,
        input  memwdata,
        output memrdata,
        output memready
    );
endinterface

// File: rtl/mips_multicycle.sv
// mips_multicycle: FSM-sequenced MIPS core. Instruction fetches and data accesses share
// one req/ready memory port, so the core tolerates variable memory latency.
// Base instructions: lw, sw, add, sub, and, or, slt, beq, addi, j.
// Optional feature macro MIPS_MULTI_EXTIMM_EN adds andi/ori (zero-extended immediate) and bne.
// When the macro is not defined, those opcodes are illegal and fault the core.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    mips_multicycle_if.master mem,
    output logic [31:0]       pc,
    output logic              retire,
    output logic              fault
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_MULTI_EXTIMM_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
`endif

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        ALUWB,
        BRANCH,
        ADDIEX,
        ADDIWB,
        JUMP,
        FAULT
    } state_t;

    state_t      state;
    state_t      nextstate;

    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] aluout;
    logic [31:0] mdr;
    logic        started;
    logic [31:0] waitcnt;
    logic [31:0] rf [32];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] signimm;
    logic [31:0] rsval;
    logic [31:0] rtval;

    logic        reqwant;
    logic        xfer;
    logic        timeout;

    logic        functok;
    logic [2:0]  functctl;
    logic [2:0]  immctl;
    logic [31:0] immop;
    logic        branchtake;

    logic        rfwe;
    logic [4:0]  rfwaddr;
    logic [31:0] rfwdata;

    function automatic logic [31:0] alu(input logic [2:0] ctl, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        case (ctl)
            ALU_AND: r = x & y;
            ALU_OR:  r = x | y;
            ALU_ADD: r = x + y;
            ALU_SUB: r = x - y;
            ALU_SLT: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: r = x + y;
        endcase
        return r;
    endfunction

    assign opcode  = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign signimm = {{16{ir[15]}}, ir[15:0]};

    assign rsval = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rtval = (rt == 5'd0) ? 32'd0 : rf[rt];

    // Requests are held off until the first edge after reset so memreq never rises during reset.
    assign reqwant = started && (state == FETCH || state == MEMRD || state == MEMWR);
    assign xfer    = reqwant && mem.memready;
    assign timeout = (WAIT_TIMEOUT != 0) && reqwant && !mem.memready
                     && (waitcnt == WAIT_TIMEOUT - 1);

    assign mem.memreq   = reqwant;
    assign mem.memwe    = started && (state == MEMWR);
    assign mem.memaddr  = (state == MEMRD || state == MEMWR) ? aluout : pc;
    assign mem.memwdata = b;

    assign fault = (state == FAULT);

    // Translate the R-type funct field into an ALU control code and flag unknown functs.
    always_comb begin
        functok  = 1'b1;
        functctl = ALU_ADD;
        case (funct)
            6'h20:   functctl = ALU_ADD;
            6'h22:   functctl = ALU_SUB;
            6'h24:   functctl = ALU_AND;
            6'h25:   functctl = ALU_OR;
            6'h2A:   functctl = ALU_SLT;
            default: functok  = 1'b0;
        endcase
    end

    // Select the operation and operand for the immediate-ALU path (addi, plus andi/ori when enabled).
    always_comb begin
        immctl = ALU_ADD;
        immop  = signimm;
`ifdef MIPS_MULTI_EXTIMM_EN
        if (opcode == OP_ANDI) begin
            immctl = ALU_AND;
            immop  = {16'd0, ir[15:0]};
        end else if (opcode == OP_ORI) begin
            immctl = ALU_OR;
            immop  = {16'd0, ir[15:0]};
        end
`endif
    end

    // Branch condition: equality for beq, inverted for bne when enabled.
    always_comb begin
        branchtake = (a == b);
`ifdef MIPS_MULTI_EXTIMM_EN
        if (opcode == OP_BNE) begin
            branchtake = (a != b);
        end
`endif
    end

    // State register; reset returns to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= nextstate;
        end
    end

    // Next-state sequencing and the retire pulse.
    always_comb begin
        nextstate = state;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                if (timeout) begin
                    nextstate = FAULT;
                end else if (xfer) begin
                    nextstate = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nextstate = MEMADR;
                    OP_RTYPE:     nextstate = EXEC;
                    OP_BEQ:       nextstate = BRANCH;
                    OP_ADDI:      nextstate = ADDIEX;
                    OP_J:         nextstate = JUMP;
`ifdef MIPS_MULTI_EXTIMM_EN
                    OP_BNE:       nextstate = BRANCH;
                    OP_ANDI,
                    OP_ORI:       nextstate = ADDIEX;
`endif
                    default:      nextstate = FAULT;
                endcase
            end
            MEMADR: begin
                nextstate = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                if (timeout) begin
                    nextstate = FAULT;
                end else if (xfer) begin
                    nextstate = MEMWB;
                end
            end
            MEMWR: begin
                if (timeout) begin
                    nextstate = FAULT;
                end else if (xfer) begin
                    retire    = 1'b1;
                    nextstate = FETCH;
                end
            end
            EXEC: begin
                nextstate = functok ? ALUWB : FAULT;
            end
            ADDIEX: begin
                nextstate = ADDIWB;
            end
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: begin
                retire    = 1'b1;
                nextstate = FETCH;
            end
            FAULT: begin
                nextstate = FAULT;
            end
            default: begin
                nextstate = FAULT;
            end
        endcase
    end

    // Datapath registers: PC, IR, operand latches, ALUOut, MDR and the memory wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= 32'd0;
            a       <= 32'd0;
            b       <= 32'd0;
            aluout  <= 32'd0;
            mdr     <= 32'd0;
            started <= 1'b0;
            waitcnt <= 32'd0;
        end else begin
            started <= 1'b1;
            if (reqwant && !mem.memready) begin
                waitcnt <= waitcnt + 32'd1;
            end else begin
                waitcnt <= 32'd0;
            end
            case (state)
                FETCH: begin
                    if (xfer) begin
                        ir <= mem.memrdata;
                        pc <= pc + 32'd4;
                    end
                end
                DECODE: begin
                    a      <= rsval;
                    b      <= rtval;
                    aluout <= pc + {signimm[29:0], 2'b00};
                end
                MEMADR: begin
                    aluout <= alu(ALU_ADD, a, signimm);
                end
                MEMRD: begin
                    if (xfer) begin
                        mdr <= mem.memrdata;
                    end
                end
                EXEC: begin
                    if (functok) begin
                        aluout <= alu(functctl, a, b);
                    end
                end
                BRANCH: begin
                    if (branchtake) begin
                        pc <= aluout;
                    end
                end
                ADDIEX: begin
                    aluout <= alu(immctl, a, immop);
                end
                JUMP: begin
                    pc <= {pc[31:28], ir[25:0], 2'b00};
                end
                default: begin
                end
            endcase
        end
    end

    // Choose the register-file write port source for the three write-back states.
    always_comb begin
        rfwe    = 1'b0;
        rfwaddr = 5'd0;
        rfwdata = 32'd0;
        case (state)
            MEMWB: begin
                rfwe    = 1'b1;
                rfwaddr = rt;
                rfwdata = mdr;
            end
            ALUWB: begin
                rfwe    = 1'b1;
                rfwaddr = rd;
                rfwdata = aluout;
            end
            ADDIWB: begin
                rfwe    = 1'b1;
                rfwaddr = rt;
                rfwdata = aluout;
            end
            default: begin
            end
        endcase
    end

    // Register file is deliberately not reset; $0 is never written and reads back as zero.
    always_ff @(posedge clk) begin
        if (rfwe && !reset && rfwaddr != 5'd0) begin
            rf[rfwaddr] <= rfwdata;
        end
    end

endmodule
